// File: rtl/sram_line_server_pkg.sv
// sram_line_server_pkg: shared types and constants for the cache-to-SRAM line server.
package sram_line_server_pkg;
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    localparam int HW_PER_LINE = 4;
    localparam int HW_PER_WORD = 2;
    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
endpackage

// File: rtl/sram_line_server_if.sv
// sram_line_server_if: cache request bus plus external SRAM pin bundle.
interface sram_line_server_if #(parameter int SRAM_AW = 18);
    logic [31:0]        addr;
    logic [31:0]        st_val;
    logic               read_en;
    logic               write_en;
    logic [63:0]        read_data;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic [15:0]        sram_dq_in;
    logic               sram_dq_oe;
    logic               sram_we_n;
    logic               sram_oe_n;
    logic               sram_ce_n;
    logic               sram_ub_n;
    logic               sram_lb_n;
    modport master (
        output addr, st_val, read_en, write_en, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe,
        input  sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
    );
    modport slave (
        input  addr, st_val, read_en, write_en, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe,
        output sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
    );
endinterface

// File: rtl/sram_line_server_access_timer.sv
// sram_access_timer: per-access cycle counter with clear and terminal count.
module sram_access_timer #(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int W = CYCLES > 1 ? $clog2(CYCLES) : 1;
    logic [W-1:0] r_cc;
    assign o_tc = i_en && (r_cc == W'(CYCLES - 1));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cc <= '0;
        else if (i_clr || o_tc)
            r_cc <= '0;
        else if (i_en)
            r_cc <= r_cc + W'(1);
    end
endmodule

// File: rtl/sram_line_server.sv
// sram_line_server: serves word writes and 64-bit line reads as 16-bit async SRAM accesses.
module sram_line_server
    import sram_line_server_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEFAULT,
    parameter int          ACCESS_CYCLES = 2,
    parameter int          SRAM_AW       = 18
) (
    input logic              clk,
    input logic              rst,
    sram_line_server_if.slave bus
);
    state_t             r_state;
    logic [1:0]         r_hw;
    logic [31:0]        r_st;
    logic [63:0]        r_read_data;
    logic [SRAM_AW-1:0] r_sram_addr;
    logic [15:0]        r_dq_out;
    logic               r_dq_oe;
    logic               r_we_n;
    logic               r_oe_n;
    logic               r_ce_n;
    logic               r_bn;
    logic [31:0]        w_off;
    logic [SRAM_AW-1:0] w_rd_base;
    logic [SRAM_AW-1:0] w_wr_base;
    logic               w_busy;
    logic               w_tc;
    logic               w_last;

    assign w_off     = bus.addr - BASE_ADDR;
    assign w_rd_base = {w_off[SRAM_AW:3], 2'b00};
    assign w_wr_base = {w_off[SRAM_AW:2], 1'b0};
    assign w_busy    = (r_state == RD) || (r_state == WR);
    assign w_last    = (r_state == RD) ? (r_hw == 2'(HW_PER_LINE - 1)) : (r_hw == 2'(HW_PER_WORD - 1));

    sram_access_timer #(.CYCLES(ACCESS_CYCLES)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .i_clr (!w_busy),
        .i_en  (w_busy),
        .o_tc  (w_tc)
    );

    // Pin controls are registered so they change only on clock edges; sram_addr steps by one per access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_hw        <= '0;
            r_st        <= '0;
            r_read_data <= '0;
            r_sram_addr <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_ce_n      <= 1'b1;
            r_bn        <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_hw <= '0;
                    if (bus.write_en) begin
                        r_state     <= WR;
                        r_st        <= bus.st_val;
                        r_sram_addr <= w_wr_base;
                        r_dq_out    <= bus.st_val[15:0];
                        r_dq_oe     <= 1'b1;
                        r_we_n      <= 1'b0;
                        r_ce_n      <= 1'b0;
                        r_bn        <= 1'b0;
                    end else if (bus.read_en) begin
                        r_state     <= RD;
                        r_sram_addr <= w_rd_base;
                        r_oe_n      <= 1'b0;
                        r_ce_n      <= 1'b0;
                        r_bn        <= 1'b0;
                    end
                end
                RD, WR: begin
                    if (w_tc) begin
                        r_hw <= r_hw + 2'd1;
                        if (r_state == RD)
                            r_read_data[{r_hw, 4'b0000} +: 16] <= bus.sram_dq_in;
                        if (w_last) begin
                            r_state <= DONE;
                            r_we_n  <= 1'b1;
                            r_oe_n  <= 1'b1;
                            r_ce_n  <= 1'b1;
                            r_bn    <= 1'b1;
                        end else begin
                            r_sram_addr <= r_sram_addr + SRAM_AW'(1);
                            r_dq_out    <= r_st[31:16];
                        end
                    end
                end
                default: begin
                    // Write data stays driven through the we_n rising edge, released on return to IDLE.
                    r_state <= IDLE;
                    r_dq_oe <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready       = (r_state == DONE) || ((r_state == IDLE) && !bus.read_en && !bus.write_en);
    assign bus.read_data   = r_read_data;
    assign bus.sram_addr   = r_sram_addr;
    assign bus.sram_dq_out = r_dq_out;
    assign bus.sram_dq_oe  = r_dq_oe;
    assign bus.sram_we_n   = r_we_n;
    assign bus.sram_oe_n   = r_oe_n;
    assign bus.sram_ce_n   = r_ce_n;
    assign bus.sram_ub_n   = r_bn;
    assign bus.sram_lb_n   = r_bn;
endmodule
